// File: rtl/idu_fwd_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : idu_fwd_pipe
//  Purpose  : Decode-stage operand forwarding and the ID/EX pipeline register.
//             - Picks each source operand from the youngest matching
//               forwarding tap, or from the GPR read data.
//             - Detects load-use / not-ready hazards and inserts bubbles.
//             - Keeps a saturating count of hazard bubbles.
//  Revision : 1.0  initial release
// ============================================================================
module idu_fwd_pipe #(
    parameter int DATA_W     = 32,
    parameter int RA_W       = 5,
    parameter int PC_W       = 30,
    parameter int PAY_W      = 48,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         if_en,
    input  logic [PC_W-1:0]              if_pc,
    input  logic [RA_W-1:0]              rs_addr_0,
    input  logic [RA_W-1:0]              rs_addr_1,
    input  logic                         rs_use_0,
    input  logic                         rs_use_1,
    input  logic [DATA_W-1:0]            gpr_rd_data_0,
    input  logic [DATA_W-1:0]            gpr_rd_data_1,
    input  logic [PAY_W-1:0]             dec_payload,
    input  logic [RA_W-1:0]              dec_dst_addr,
    input  logic                         dec_gpr_we_,
    input  logic [FWD_STAGES-1:0]        fwd_gpr_we_,
    input  logic [FWD_STAGES*RA_W-1:0]   fwd_dst_addr,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
    input  logic [FWD_STAGES-1:0]        fwd_rdy,
    output logic [DATA_W-1:0]            opnd_0,
    output logic [DATA_W-1:0]            opnd_1,
    output logic                         ld_hazard,
    output logic                         id_en,
    output logic [PC_W-1:0]              id_pc,
    output logic [PAY_W-1:0]             id_payload,
    output logic [DATA_W-1:0]            id_opnd_0,
    output logic [DATA_W-1:0]            id_opnd_1,
    output logic [RA_W-1:0]              id_dst_addr,
    output logic                         id_gpr_we_,
    output logic [CNT_W-1:0]             hz_stall_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // Per-tap match vectors for each source operand
    logic [FWD_STAGES-1:0] w_hit_0;
    logic [FWD_STAGES-1:0] w_hit_1;

    // Selected operands and per-source not-ready flags
    logic [DATA_W-1:0]     w_opnd_0;
    logic [DATA_W-1:0]     w_opnd_1;
    logic                  w_nrdy_0;
    logic                  w_nrdy_1;
    logic                  w_ld_hazard;

    // ID/EX register
    logic                  r_en;
    logic [PC_W-1:0]       r_pc;
    logic [PAY_W-1:0]      r_payload;
    logic [DATA_W-1:0]     r_opnd_0;
    logic [DATA_W-1:0]     r_opnd_1;
    logic [RA_W-1:0]       r_dst_addr;
    logic                  r_gpr_we_;
    logic [CNT_W-1:0]      r_hz_cnt;

    // A tap matches a source only when the source is really read, the tap
    // is writing, the addresses agree, and the register is not r0.
    generate
        for (genvar k = 0; k < FWD_STAGES; k++) begin : g_tap
            assign w_hit_0[k] = rs_use_0 & ~fwd_gpr_we_[k]
                              & (fwd_dst_addr[k*RA_W +: RA_W] == rs_addr_0)
                              & (rs_addr_0 != '0);
            assign w_hit_1[k] = rs_use_1 & ~fwd_gpr_we_[k]
                              & (fwd_dst_addr[k*RA_W +: RA_W] == rs_addr_1)
                              & (rs_addr_1 != '0);
        end
    endgenerate

    // Source 0: walk oldest to youngest so the youngest matching tap wins
    always_comb begin
        w_opnd_0 = gpr_rd_data_0;
        w_nrdy_0 = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (w_hit_0[k]) begin
                w_opnd_0 = fwd_data[k*DATA_W +: DATA_W];
                w_nrdy_0 = ~fwd_rdy[k];
            end
        end
    end

    // Source 1: same youngest-wins selection as source 0
    always_comb begin
        w_opnd_1 = gpr_rd_data_1;
        w_nrdy_1 = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (w_hit_1[k]) begin
                w_opnd_1 = fwd_data[k*DATA_W +: DATA_W];
                w_nrdy_1 = ~fwd_rdy[k];
            end
        end
    end

    // Only the youngest match decides readiness, so an older ready copy of
    // the same register can never hide a pending load result.
    assign w_ld_hazard = if_en & (w_nrdy_0 | w_nrdy_1);

    // ID/EX register: reset, then stall (hold), flush, bubble, normal load
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_en       <= 1'b0;
            r_gpr_we_  <= 1'b1;
            r_pc       <= '0;
            r_payload  <= '0;
            r_opnd_0   <= '0;
            r_opnd_1   <= '0;
            r_dst_addr <= '0;
        end else if (stall) begin
            r_en       <= r_en;
            r_gpr_we_  <= r_gpr_we_;
        end else if (flush) begin
            r_en       <= 1'b0;
            r_gpr_we_  <= 1'b1;
            r_pc       <= '0;
            r_payload  <= '0;
            r_opnd_0   <= '0;
            r_opnd_1   <= '0;
            r_dst_addr <= '0;
        end else if (w_ld_hazard) begin
            // Bubble: data fields are meaningless once id_en is low
            r_en       <= 1'b0;
            r_gpr_we_  <= 1'b1;
        end else begin
            r_en       <= if_en;
            r_gpr_we_  <= dec_gpr_we_ | ~if_en;
            r_pc       <= if_pc;
            r_payload  <= dec_payload;
            r_opnd_0   <= w_opnd_0;
            r_opnd_1   <= w_opnd_1;
            r_dst_addr <= dec_dst_addr;
        end
    end

    // Saturating count of bubbles actually inserted (stall/flush win over hazard)
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hz_cnt <= '0;
        end else if (!stall && !flush && w_ld_hazard && (r_hz_cnt != C_CNT_MAX)) begin
            r_hz_cnt <= r_hz_cnt + 1'b1;
        end
    end

    assign opnd_0       = w_opnd_0;
    assign opnd_1       = w_opnd_1;
    assign ld_hazard    = w_ld_hazard;
    assign id_en        = r_en;
    assign id_pc        = r_pc;
    assign id_payload   = r_payload;
    assign id_opnd_0    = r_opnd_0;
    assign id_opnd_1    = r_opnd_1;
    assign id_dst_addr  = r_dst_addr;
    assign id_gpr_we_   = r_gpr_we_;
    assign hz_stall_cnt = r_hz_cnt;

endmodule
`default_nettype wire

// File: tb/tb_idu_fwd_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idu_fwd_pipe
//  Purpose  : Directed scoreboard bench for idu_fwd_pipe (default widths plus
//             a CNT_W=4 copy sharing the same stimulus for saturation).
//  Revision : 1.0  initial release
// ============================================================================
module tb_idu_fwd_pipe;

    logic        clk = 1'b0;
    logic        reset, stall, flush, if_en;
    logic [29:0] if_pc;
    logic [4:0]  rs_addr_0, rs_addr_1;
    logic        rs_use_0, rs_use_1;
    logic [31:0] gpr_rd_data_0, gpr_rd_data_1;
    logic [47:0] dec_payload;
    logic [4:0]  dec_dst_addr;
    logic        dec_gpr_we_;
    logic [1:0]  fwd_gpr_we_;
    logic [9:0]  fwd_dst_addr;
    logic [63:0] fwd_data;
    logic [1:0]  fwd_rdy;

    logic [31:0] opnd_0, opnd_1, id_opnd_0, id_opnd_1;
    logic        ld_hazard, id_en, id_gpr_we_;
    logic [29:0] id_pc;
    logic [47:0] id_payload;
    logic [4:0]  id_dst_addr;
    logic [15:0] hz_stall_cnt;

    logic [31:0] s_opnd_0, s_opnd_1, s_id_opnd_0, s_id_opnd_1;
    logic        s_ld_hazard, s_id_en, s_id_gpr_we_;
    logic [29:0] s_id_pc;
    logic [47:0] s_id_payload;
    logic [4:0]  s_id_dst_addr;
    logic [3:0]  s_hz_stall_cnt;

    always #5 clk = ~clk;

    idu_fwd_pipe dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .if_en(if_en), .if_pc(if_pc),
        .rs_addr_0(rs_addr_0), .rs_addr_1(rs_addr_1),
        .rs_use_0(rs_use_0), .rs_use_1(rs_use_1),
        .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
        .dec_payload(dec_payload), .dec_dst_addr(dec_dst_addr), .dec_gpr_we_(dec_gpr_we_),
        .fwd_gpr_we_(fwd_gpr_we_), .fwd_dst_addr(fwd_dst_addr),
        .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
        .opnd_0(opnd_0), .opnd_1(opnd_1), .ld_hazard(ld_hazard),
        .id_en(id_en), .id_pc(id_pc), .id_payload(id_payload),
        .id_opnd_0(id_opnd_0), .id_opnd_1(id_opnd_1),
        .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_),
        .hz_stall_cnt(hz_stall_cnt)
    );

    idu_fwd_pipe #(.CNT_W(4)) dut_c4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .if_en(if_en), .if_pc(if_pc),
        .rs_addr_0(rs_addr_0), .rs_addr_1(rs_addr_1),
        .rs_use_0(rs_use_0), .rs_use_1(rs_use_1),
        .gpr_rd_data_0(gpr_rd_data_0), .gpr_rd_data_1(gpr_rd_data_1),
        .dec_payload(dec_payload), .dec_dst_addr(dec_dst_addr), .dec_gpr_we_(dec_gpr_we_),
        .fwd_gpr_we_(fwd_gpr_we_), .fwd_dst_addr(fwd_dst_addr),
        .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
        .opnd_0(s_opnd_0), .opnd_1(s_opnd_1), .ld_hazard(s_ld_hazard),
        .id_en(s_id_en), .id_pc(s_id_pc), .id_payload(s_id_payload),
        .id_opnd_0(s_id_opnd_0), .id_opnd_1(s_id_opnd_1),
        .id_dst_addr(s_id_dst_addr), .id_gpr_we_(s_id_gpr_we_),
        .hz_stall_cnt(s_hz_stall_cnt)
    );

    // Expected response for one cycle; c_* flags select which groups to check
    typedef struct packed {
        logic        c_comb;
        logic [31:0] opnd0;
        logic [31:0] opnd1;
        logic        hz;
        logic        c_ctl;
        logic        en;
        logic        we_;
        logic        c_dat;
        logic [29:0] pc;
        logic [47:0] pay;
        logic [31:0] io0;
        logic [31:0] io1;
        logic [4:0]  dst;
        logic        c_cnt;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    exp_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t blank();
        exp_t x;
        x = '0;
        return x;
    endfunction

    task automatic idle();
        stall = 0; flush = 0; if_en = 0; if_pc = '0;
        rs_addr_0 = 0; rs_addr_1 = 0; rs_use_0 = 0; rs_use_1 = 0;
        gpr_rd_data_0 = 0; gpr_rd_data_1 = 0;
        dec_payload = '0; dec_dst_addr = 0; dec_gpr_we_ = 1;
        fwd_gpr_we_ = 2'b11; fwd_dst_addr = '0; fwd_data = '0; fwd_rdy = 2'b11;
    endtask

    task automatic tap(input int k, input logic we_, input logic [4:0] dst,
                       input logic [31:0] d, input logic rdy);
        fwd_gpr_we_[k]        = we_;
        fwd_dst_addr[k*5 +: 5] = dst;
        fwd_data[k*32 +: 32]   = d;
        fwd_rdy[k]             = rdy;
    endtask

    task automatic go(input exp_t x);
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: each cycle the DUT presents a result just after the edge
    initial begin
        exp_t m;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                m = sb.pop_front();
                if (m.c_comb) begin
                    chk("opnd_0", 64'(opnd_0), 64'(m.opnd0));
                    chk("opnd_1", 64'(opnd_1), 64'(m.opnd1));
                    chk("ld_hazard", 64'(ld_hazard), 64'(m.hz));
                end
                if (m.c_ctl) begin
                    chk("id_en", 64'(id_en), 64'(m.en));
                    chk("id_gpr_we_", 64'(id_gpr_we_), 64'(m.we_));
                end
                if (m.c_dat) begin
                    chk("id_pc", 64'(id_pc), 64'(m.pc));
                    chk("id_payload", 64'(id_payload), 64'(m.pay));
                    chk("id_opnd_0", 64'(id_opnd_0), 64'(m.io0));
                    chk("id_opnd_1", 64'(id_opnd_1), 64'(m.io1));
                    chk("id_dst_addr", 64'(id_dst_addr), 64'(m.dst));
                end
                if (m.c_cnt) begin
                    chk("hz_stall_cnt", 64'(hz_stall_cnt), 64'(m.cnt));
                    chk("hz_stall_cnt_w4", 64'(s_hz_stall_cnt), 64'(m.cnt4));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with busy-looking inputs: everything must clear
        idle();
        reset = 0; if_en = 1; if_pc = 30'h155; dec_payload = 48'hDEAD;
        dec_gpr_we_ = 0; dec_dst_addr = 7; gpr_rd_data_0 = 32'h1234;
        @(negedge clk);
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h1234; e.opnd1 = 0; e.hz = 0;
        e.c_ctl = 1; e.en = 0; e.we_ = 1; e.c_dat = 1; e.c_cnt = 1;
        go(e);

        // Youngest tap wins when both taps hold r3
        reset = 1; idle();
        if_en = 1; if_pc = 30'h100; dec_payload = 48'h1234_5678_9ABC;
        dec_dst_addr = 9; dec_gpr_we_ = 0;
        rs_addr_0 = 3; rs_use_0 = 1; rs_addr_1 = 7; rs_use_1 = 1;
        gpr_rd_data_0 = 32'hAAAA; gpr_rd_data_1 = 32'hBBBB;
        tap(0, 0, 3, 32'h11, 1); tap(1, 0, 3, 32'h22, 1);
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h11; e.opnd1 = 32'hBBBB; e.hz = 0;
        e.c_ctl = 1; e.en = 1; e.we_ = 0;
        e.c_dat = 1; e.pc = 30'h100; e.pay = 48'h1234_5678_9ABC;
        e.io0 = 32'h11; e.io1 = 32'hBBBB; e.dst = 9; e.c_cnt = 1;
        go(e);

        // Tap0 idle -> older tap forwards; unused source ignores its match; if_en=0
        tap(0, 1, 3, 32'h11, 1);
        if_en = 0; if_pc = 30'h101; rs_addr_1 = 3; rs_use_1 = 0;
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h22; e.opnd1 = 32'hBBBB; e.hz = 0;
        e.c_ctl = 1; e.en = 0; e.we_ = 1;
        e.c_dat = 1; e.pc = 30'h101; e.pay = 48'h1234_5678_9ABC;
        e.io0 = 32'h22; e.io1 = 32'hBBBB; e.dst = 9; e.c_cnt = 1;
        go(e);

        // Load-use on source 1: bubble, count 1
        idle();
        if_en = 1; if_pc = 30'h102; dec_gpr_we_ = 0; dec_dst_addr = 10; dec_payload = 48'h3;
        rs_addr_0 = 2; rs_use_0 = 1; gpr_rd_data_0 = 32'h2;
        rs_addr_1 = 5; rs_use_1 = 1; gpr_rd_data_1 = 32'h99;
        tap(0, 0, 5, 32'h55, 0);
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h2; e.opnd1 = 32'h55; e.hz = 1;
        e.c_ctl = 1; e.en = 0; e.we_ = 1; e.c_cnt = 1; e.cnt = 1; e.cnt4 = 1;
        go(e);

        // Load data arrives: instruction proceeds
        tap(0, 0, 5, 32'h55, 1);
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h2; e.opnd1 = 32'h55; e.hz = 0;
        e.c_ctl = 1; e.en = 1; e.we_ = 0;
        e.c_dat = 1; e.pc = 30'h102; e.pay = 48'h3; e.io0 = 32'h2; e.io1 = 32'h55; e.dst = 10;
        e.c_cnt = 1; e.cnt = 1; e.cnt4 = 1;
        go(e);

        // Older ready tap must not mask younger not-ready tap
        rs_addr_0 = 6; gpr_rd_data_0 = 32'h0;
        tap(0, 0, 6, 32'h66, 0); tap(1, 0, 6, 32'h77, 1);
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h66; e.opnd1 = 32'h99; e.hz = 1;
        e.c_ctl = 1; e.en = 0; e.we_ = 1; e.c_cnt = 1; e.cnt = 2; e.cnt4 = 2;
        go(e);

        // Younger ready tap shadows an older not-ready one
        tap(0, 0, 6, 32'h66, 1); tap(1, 0, 6, 32'h77, 0); if_pc = 30'h103;
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h66; e.opnd1 = 32'h99; e.hz = 0;
        e.c_ctl = 1; e.en = 1; e.we_ = 0;
        e.c_dat = 1; e.pc = 30'h103; e.pay = 48'h3; e.io0 = 32'h66; e.io1 = 32'h99; e.dst = 10;
        e.c_cnt = 1; e.cnt = 2; e.cnt4 = 2;
        go(e);

        // Not-ready match without a valid IF/ID entry: no hazard
        tap(0, 0, 6, 32'h66, 0); if_en = 0;
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h66; e.opnd1 = 32'h99; e.hz = 0;
        e.c_ctl = 1; e.en = 0; e.we_ = 1; e.c_cnt = 1; e.cnt = 2; e.cnt4 = 2;
        go(e);

        // Sources not used: GPR data passes through, no hazard
        if_en = 1; if_pc = 30'h104; rs_use_0 = 0; rs_use_1 = 0;
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h0; e.opnd1 = 32'h99; e.hz = 0;
        e.c_ctl = 1; e.en = 1; e.we_ = 0;
        e.c_dat = 1; e.pc = 30'h104; e.pay = 48'h3; e.io0 = 32'h0; e.io1 = 32'h99; e.dst = 10;
        e.c_cnt = 1; e.cnt = 2; e.cnt4 = 2;
        go(e);

        // r0 never forwards and never stalls
        idle();
        if_en = 1; if_pc = 30'h105; dec_gpr_we_ = 1;
        rs_addr_0 = 0; rs_use_0 = 1; gpr_rd_data_0 = 32'h0;
        tap(0, 0, 0, 32'hFF, 0);
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h0; e.opnd1 = 32'h0; e.hz = 0;
        e.c_ctl = 1; e.en = 1; e.we_ = 1;
        e.c_dat = 1; e.pc = 30'h105; e.c_cnt = 1; e.cnt = 2; e.cnt4 = 2;
        go(e);

        // Load a known entry before exercising stall/flush
        idle();
        if_en = 1; if_pc = 30'h200; dec_payload = 48'hABCD; dec_dst_addr = 4; dec_gpr_we_ = 0;
        rs_addr_0 = 1; rs_use_0 = 1; gpr_rd_data_0 = 32'h1111;
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h1111; e.opnd1 = 32'h0; e.hz = 0;
        e.c_ctl = 1; e.en = 1; e.we_ = 0;
        e.c_dat = 1; e.pc = 30'h200; e.pay = 48'hABCD; e.io0 = 32'h1111; e.io1 = 32'h0; e.dst = 4;
        e.c_cnt = 1; e.cnt = 2; e.cnt4 = 2;
        go(e);

        // stall+flush+hazard: everything holds, counter included
        stall = 1; flush = 1; if_pc = 30'h201; dec_payload = 48'h1;
        rs_addr_1 = 5; rs_use_1 = 1; tap(0, 0, 5, 32'h5, 0);
        e.opnd1 = 32'h5; e.hz = 1;
        go(e);

        // flush+hazard: bubble from flush, counter unchanged
        stall = 0;
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h1111; e.opnd1 = 32'h5; e.hz = 1;
        e.c_ctl = 1; e.en = 0; e.we_ = 1; e.c_cnt = 1; e.cnt = 2; e.cnt4 = 2;
        go(e);

        // Plain hazard bubble: counter advances
        flush = 0;
        e.cnt = 3; e.cnt4 = 3;
        go(e);

        // Reset in the middle of a stall: register clears, hazard stays combinational
        reset = 0;
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h1111; e.opnd1 = 32'h5; e.hz = 1;
        e.c_ctl = 1; e.en = 0; e.we_ = 1; e.c_dat = 1; e.c_cnt = 1;
        go(e);

        // 20 consecutive hazard cycles: narrow counter saturates at 15
        reset = 1;
        for (int i = 1; i <= 20; i++) begin
            e = blank(); e.c_comb = 1; e.opnd0 = 32'h1111; e.opnd1 = 32'h5; e.hz = 1;
            e.c_ctl = 1; e.en = 0; e.we_ = 1; e.c_cnt = 1;
            e.cnt = 16'(i); e.cnt4 = (i > 15) ? 4'd15 : 4'(i);
            go(e);
        end

        // Producer ready again: entry passes, counters hold
        tap(0, 0, 5, 32'h5, 1);
        e = blank(); e.c_comb = 1; e.opnd0 = 32'h1111; e.opnd1 = 32'h5; e.hz = 0;
        e.c_ctl = 1; e.en = 1; e.we_ = 0;
        e.c_dat = 1; e.pc = 30'h201; e.pay = 48'h1; e.io0 = 32'h1111; e.io1 = 32'h5; e.dst = 4;
        e.c_cnt = 1; e.cnt = 16'd20; e.cnt4 = 4'd15;
        go(e);

        idle();
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
